sr_mem_arb: RTL and testbench

SR_MEM_ARB -- requirements
Module: sr_mem_arb

---
 rtl/sr_mem_arb_if.sv | 29 ++
 rtl/sr_mem_arb.sv | 220 ++++++++++++++++++++++
 tb/tb_sr_mem_arb.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_mem_arb_if
// Purpose  : request/response bundle for one requester of sr_mem_arb.
// Revision : 1.0
// ============================================================================
interface sr_mem_arb_if;
   logic        req;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [1:0]  size;
   logic        sign;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, addr, wdata, we, size, sign,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, wdata, we, size, sign,
      output gnt, rvalid, rdata, err
   );
endinterface
`default_nettype wire

// File: rtl/sr_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : sr_mem_arb
// Purpose  : two-requester round-robin arbiter in front of a byte-addressable
//            RAM with a fixed grant -> access -> response sequence.
// Revision : 1.0
// ============================================================================
module sr_mem_arb #(
   parameter int DEPTH = 256
) (
   input  logic         clk,
   input  logic         rst,
   sr_mem_arb_if.slave  m0,
   sr_mem_arb_if.slave  m1,
   output logic [31:0]  ram_addr,
   output logic [31:0]  ram_wdata,
   output logic         ram_we,
   output logic         ram_sign,
   output logic         ram_op_word,
   output logic         ram_op_half,
   output logic         ram_op_byte,
   input  logic [31:0]  ram_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [32:0] c_depth_w = 33'(DEPTH);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        sign_q, sign_d;
   logic        id_q, id_d;
   logic        err_q, err_d;
   logic        last_q, last_d;

   logic        w_any_req;
   logic        w_sel_id;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic        w_sel_we;
   logic [1:0]  w_sel_size;
   logic        w_sel_sign;
   logic [32:0] w_sel_bytes;
   logic [32:0] w_sel_end;
   logic        w_sel_err;
   logic [31:0] w_resp_data;

   logic        w_gnt0, w_gnt1;
   logic        w_rvalid0, w_rvalid1;
   logic        w_err0, w_err1;
   logic [31:0] w_rdata0, w_rdata1;

   // Candidate command: the lone requester, or on contention the one not served last.
   always_comb begin
      w_any_req = m0.req | m1.req;
      w_sel_id  = (m0.req && m1.req) ? ~last_q : m1.req;
      if (w_sel_id) begin
         w_sel_addr  = m1.addr;
         w_sel_wdata = m1.wdata;
         w_sel_we    = m1.we;
         w_sel_size  = m1.size;
         w_sel_sign  = m1.sign;
      end else begin
         w_sel_addr  = m0.addr;
         w_sel_wdata = m0.wdata;
         w_sel_we    = m0.we;
         w_sel_size  = m0.size;
         w_sel_sign  = m0.sign;
      end
      case (w_sel_size)
         2'b00:   w_sel_bytes = 33'd1;
         2'b01:   w_sel_bytes = 33'd2;
         default: w_sel_bytes = 33'd4;
      endcase
      // 33-bit sum so an address near 2^32 cannot wrap back into range
      w_sel_end = {1'b0, w_sel_addr} + w_sel_bytes;
      w_sel_err = (w_sel_size == 2'b11)
               || ((w_sel_size == 2'b01) && w_sel_addr[0])
               || ((w_sel_size == 2'b10) && (w_sel_addr[1:0] != 2'b00))
               || (w_sel_end > c_depth_w);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      size_d      = size_q;
      we_d        = we_q;
      sign_d      = sign_q;
      id_d        = id_q;
      err_d       = err_q;
      last_d      = last_q;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_rvalid0   = 1'b0;
      w_rvalid1   = 1'b0;
      w_err0      = 1'b0;
      w_err1      = 1'b0;
      w_rdata0    = 32'd0;
      w_rdata1    = 32'd0;
      ram_addr    = 32'd0;
      ram_wdata   = 32'd0;
      ram_we      = 1'b0;
      ram_sign    = 1'b0;
      ram_op_word = 1'b0;
      ram_op_half = 1'b0;
      ram_op_byte = 1'b0;
      w_resp_data = (we_q || err_q) ? 32'd0 : rdata_q;

      case (state_q)
         S_IDLE: begin
            if (w_any_req) begin
               w_gnt0  = ~w_sel_id;
               w_gnt1  = w_sel_id;
               addr_d  = w_sel_addr;
               wdata_d = w_sel_wdata;
               we_d    = w_sel_we;
               size_d  = w_sel_size;
               sign_d  = w_sel_sign;
               id_d    = w_sel_id;
               err_d   = w_sel_err;
               last_d  = w_sel_id;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
            // A rejected command still spends its ACCESS cycle, but never touches the RAM
            if (!err_q) begin
               ram_we      = we_q;
               ram_sign    = sign_q;
               ram_op_byte = (size_q == 2'b00);
               ram_op_half = (size_q == 2'b01);
               ram_op_word = (size_q == 2'b10);
            end
            rdata_d = ram_rdata;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (id_q) begin
               w_rvalid1 = 1'b1;
               w_err1    = err_q;
               w_rdata1  = w_resp_data;
            end else begin
               w_rvalid0 = 1'b1;
               w_err0    = err_q;
               w_rdata0  = w_resp_data;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Reset silences everything at once, including a store in flight
      if (rst) begin
         w_gnt0      = 1'b0;
         w_gnt1      = 1'b0;
         w_rvalid0   = 1'b0;
         w_rvalid1   = 1'b0;
         w_err0      = 1'b0;
         w_err1      = 1'b0;
         w_rdata0    = 32'd0;
         w_rdata1    = 32'd0;
         ram_addr    = 32'd0;
         ram_wdata   = 32'd0;
         ram_we      = 1'b0;
         ram_sign    = 1'b0;
         ram_op_word = 1'b0;
         ram_op_half = 1'b0;
         ram_op_byte = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         size_q  <= 2'd0;
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         we_q    <= we_d;
         sign_q  <= sign_d;
         id_q    <= id_d;
         err_q   <= err_d;
         last_q  <= last_d;
      end
   end

   assign m0.gnt    = w_gnt0;
   assign m0.rvalid = w_rvalid0;
   assign m0.err    = w_err0;
   assign m0.rdata  = w_rdata0;
   assign m1.gnt    = w_gnt1;
   assign m1.rvalid = w_rvalid1;
   assign m1.err    = w_err1;
   assign m1.rdata  = w_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_sr_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_mem_arb
// Purpose  : self-checking bench for sr_mem_arb with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_sr_mem_arb;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic        ram_we, ram_sign, ram_op_word, ram_op_half, ram_op_byte;

   sr_mem_arb_if m0_if ();
   sr_mem_arb_if m1_if ();

   sr_mem_arb #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .m0          (m0_if),
      .m1          (m1_if),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_we      (ram_we),
      .ram_sign    (ram_sign),
      .ram_op_word (ram_op_word),
      .ram_op_half (ram_op_half),
      .ram_op_byte (ram_op_byte),
      .ram_rdata   (ram_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // External RAM: little-endian bytes, combinational read, write on clock edge
   logic [7:0] ram_mem [0:255];
   logic [7:0] ref_mem [0:255];

   always_comb begin
      logic [7:0] a;
      a = ram_addr[7:0];
      ram_rdata = 32'hA5A5_A5A5;
      if (ram_op_byte)
         ram_rdata = {{24{ram_sign & ram_mem[a][7]}}, ram_mem[a]};
      else if (ram_op_half)
         ram_rdata = {{16{ram_sign & ram_mem[a + 8'd1][7]}}, ram_mem[a + 8'd1], ram_mem[a]};
      else if (ram_op_word)
         ram_rdata = {ram_mem[a + 8'd3], ram_mem[a + 8'd2], ram_mem[a + 8'd1], ram_mem[a]};
   end

   always @(posedge clk) begin
      if (ram_we) begin
         if (ram_op_byte || ram_op_half || ram_op_word) ram_mem[ram_addr[7:0]] = ram_wdata[7:0];
         if (ram_op_half || ram_op_word) ram_mem[ram_addr[7:0] + 8'd1] = ram_wdata[15:8];
         if (ram_op_word) begin
            ram_mem[ram_addr[7:0] + 8'd2] = ram_wdata[23:16];
            ram_mem[ram_addr[7:0] + 8'd3] = ram_wdata[31:24];
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic bit mdl_err(input logic [31:0] a, input logic [1:0] s);
      longint nb;
      if (s == 2'b11) return 1'b1;
      nb = longint'(1) << s;
      if ((longint'(a) % nb) != 0) return 1'b1;
      return (longint'(a) + nb) > DEPTH;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] s, input bit sx);
      int     nb;
      longint v;
      nb = 1 << s;
      v  = 0;
      for (int i = 0; i < nb; i++) v = v | (longint'(ref_mem[int'(a) + i]) << (8 * i));
      if (sx && v[8 * nb - 1]) v = v - (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction

   task automatic mdl_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
      for (int i = 0; i < (1 << s); i++) ref_mem[int'(a) + i] = wd[8 * i +: 8];
   endtask

   int          cyc = 0;
   int          free_cyc = 0;
   bit          last_g = 1'b1;
   bit          t_act = 1'b0;
   bit          t_id, t_we, t_sign, t_err;
   logic [31:0] t_addr, t_wdata;
   logic [1:0]  t_size;
   int          t_g;

   int          g_cyc  [2];
   int          rv_cyc [2];
   int          rv_cnt [2];
   logic [31:0] rv_data[2];
   logic        rv_err [2];

   always @(negedge clk) begin
      logic [1:0]  e_gnt, e_rv;
      logic        e_er;
      logic [31:0] e_rd, e_ad, e_wd;
      logic [4:0]  e_ctl, ctl_mask;
      bit          chk_bus, w;
      cyc = cyc + 1;
      if (rst) begin
         chk("rst_gnt", {m1_if.gnt, m0_if.gnt}, 0);
         chk("rst_resp", {m1_if.rvalid, m0_if.rvalid, m1_if.err, m0_if.err}, 0);
         chk("rst_rdata", m0_if.rdata | m1_if.rdata, 0);
         chk("rst_ram_ctl", {ram_we, ram_sign, ram_op_word, ram_op_half, ram_op_byte}, 0);
         chk("rst_ram_bus", ram_addr | ram_wdata, 0);
         t_act    = 1'b0;
         free_cyc = cyc + 1;
         last_g   = 1'b1;
      end else begin
         e_gnt = 0; e_rv = 0; e_er = 0; e_rd = 0; e_ad = 0; e_wd = 0; e_ctl = 0;
         chk_bus  = 1'b1;
         ctl_mask = 5'b11111;
         if (t_act && cyc == t_g + 1) begin
            if (t_err) begin
               chk_bus  = 1'b0;
               ctl_mask = 5'b10111;
            end else begin
               e_ctl = {t_we, t_sign, 3'(1 << t_size)};
               e_ad  = t_addr;
               e_wd  = t_wdata;
               if (t_we) mdl_store(t_addr, t_size, t_wdata);
            end
         end
         if (t_act && cyc == t_g + 2) begin
            e_rv[t_id] = 1'b1;
            e_er       = t_err;
            e_rd       = (t_err || t_we) ? 32'd0 : mdl_load(t_addr, t_size, t_sign);
            t_act      = 1'b0;
         end
         if (cyc >= free_cyc && (m0_if.req || m1_if.req)) begin
            w = (m0_if.req && m1_if.req) ? !last_g : m1_if.req;
            if (w) begin
               t_addr = m1_if.addr; t_wdata = m1_if.wdata; t_we = m1_if.we;
               t_size = m1_if.size; t_sign = m1_if.sign;
            end else begin
               t_addr = m0_if.addr; t_wdata = m0_if.wdata; t_we = m0_if.we;
               t_size = m0_if.size; t_sign = m0_if.sign;
            end
            t_id     = w;
            t_err    = mdl_err(t_addr, t_size);
            t_act    = 1'b1;
            t_g      = cyc;
            free_cyc = cyc + 3;
            last_g   = w;
            e_gnt[w] = 1'b1;
         end
         chk("gnt", {m1_if.gnt, m0_if.gnt}, e_gnt);
         chk("rvalid", {m1_if.rvalid, m0_if.rvalid}, e_rv);
         chk("err0", m0_if.err, e_rv[0] ? e_er : 1'b0);
         chk("err1", m1_if.err, e_rv[1] ? e_er : 1'b0);
         chk("rdata0", m0_if.rdata, e_rv[0] ? e_rd : 32'd0);
         chk("rdata1", m1_if.rdata, e_rv[1] ? e_rd : 32'd0);
         chk("ram_ctl", {ram_we, ram_sign, ram_op_word, ram_op_half, ram_op_byte} & ctl_mask, e_ctl);
         if (chk_bus) begin
            chk("ram_addr", ram_addr, e_ad);
            chk("ram_wdata", ram_wdata, e_wd);
         end
      end
      if (m0_if.gnt) g_cyc[0] = cyc;
      if (m1_if.gnt) g_cyc[1] = cyc;
      if (m0_if.rvalid) begin
         rv_cyc[0] = cyc; rv_data[0] = m0_if.rdata; rv_err[0] = m0_if.err; rv_cnt[0]++;
      end
      if (m1_if.rvalid) begin
         rv_cyc[1] = cyc; rv_data[1] = m1_if.rdata; rv_err[1] = m1_if.err; rv_cnt[1]++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_cmd(input bit id, input logic [31:0] a, input logic [31:0] wd,
                          input bit we, input logic [1:0] sz, input bit sx);
      if (id) begin
         m1_if.addr = a; m1_if.wdata = wd; m1_if.we = we; m1_if.size = sz; m1_if.sign = sx;
      end else begin
         m0_if.addr = a; m0_if.wdata = wd; m0_if.we = we; m0_if.size = sz; m0_if.sign = sx;
      end
   endtask

   task automatic run(input bit use0, input bit use1);
      bit p0, p1, d0, d1;
      int n;
      @(posedge clk); #1;
      m0_if.req = use0; m1_if.req = use1;
      p0 = use0; p1 = use1; n = 0;
      while ((p0 || p1) && n < 40) begin
         @(negedge clk);
         n++;
         d0 = p0 && m0_if.gnt;
         d1 = p1 && m1_if.gnt;
         @(posedge clk); #1;
         if (d0) begin m0_if.req = 1'b0; p0 = 1'b0; end
         if (d1) begin m1_if.req = 1'b0; p1 = 1'b0; end
      end
      chk("grant_timeout", {p1, p0}, 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int  n0, n;
      bit  got;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = i[7:0] ^ 8'h5A;
         ref_mem[i] = i[7:0] ^ 8'h5A;
      end
      m0_if.req = 1'b0; m1_if.req = 1'b0;
      set_cmd(0, 0, 0, 0, 0, 0);
      set_cmd(1, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // word store then sign-extended byte load of its top byte
      set_cmd(0, 32'h10, 32'hDEADBEEF, 1, 2'b10, 0); run(1, 0);
      chk("st_word_err", rv_err[0], 0);
      chk("st_word_rdata", rv_data[0], 0);
      set_cmd(0, 32'h13, 32'h0, 0, 2'b00, 1); run(1, 0);
      chk("ld_byte_latency", rv_cyc[0] - g_cyc[0], 2);
      chk("ld_byte_data", rv_data[0], 32'hFFFFFFDE);
      chk("ld_byte_err", rv_err[0], 0);

      // contention after reset: m0 first; after m0 alone, m1 first
      do_reset();
      set_cmd(0, 32'h10, 0, 0, 2'b10, 0);
      set_cmd(1, 32'h14, 0, 0, 2'b10, 0);
      run(1, 1);
      chk("rr_m0_first", g_cyc[1] - g_cyc[0], 3);
      chk("rr_m0_data", rv_data[0], 32'hDEADBEEF);
      chk("rr_m1_data", rv_data[1], 32'h4D4C4F4E);
      set_cmd(0, 32'h13, 0, 0, 2'b00, 0); run(1, 0);
      chk("ld_byte_unsigned", rv_data[0], 32'h000000DE);
      set_cmd(0, 32'h10, 0, 0, 2'b10, 0);
      run(1, 1);
      chk("rr_m1_first", g_cyc[0] - g_cyc[1], 3);

      // rejected accesses and range boundaries
      set_cmd(1, 32'h21, 0, 0, 2'b01, 0); run(0, 1);
      chk("half_misalign_err", rv_err[1], 1);
      chk("half_misalign_rdata", rv_data[1], 0);
      set_cmd(0, 32'hFE, 32'hCAFEF00D, 1, 2'b10, 0); run(1, 0);
      chk("word_oob_err", rv_err[0], 1);
      chk("word_oob_ram_fe", {ram_mem[8'hFF], ram_mem[8'hFE]}, 16'hA5A4);
      set_cmd(0, 32'hFC, 0, 0, 2'b10, 0); run(1, 0);
      chk("word_top_data", rv_data[0], 32'hA5A4A7A6);
      chk("word_top_err", rv_err[0], 0);
      set_cmd(1, 32'hFF, 0, 0, 2'b00, 1); run(0, 1);
      chk("byte_last_data", rv_data[1], 32'hFFFFFFA5);
      set_cmd(1, 32'h100, 0, 0, 2'b00, 0); run(0, 1);
      chk("byte_oob_err", rv_err[1], 1);
      set_cmd(0, 32'h20, 0, 0, 2'b11, 0); run(1, 0);
      chk("size11_err", rv_err[0], 1);
      set_cmd(0, 32'h02, 0, 0, 2'b10, 0); run(1, 0);
      chk("word_misalign_err", rv_err[0], 1);
      chk("word_misalign_rdata", rv_data[0], 0);

      // half store by m0, half loads by m1
      set_cmd(0, 32'h40, 32'h1234ABCD, 1, 2'b01, 0); run(1, 0);
      set_cmd(1, 32'h40, 0, 0, 2'b01, 0); run(0, 1);
      chk("half_zext", rv_data[1], 32'h0000ABCD);
      set_cmd(1, 32'h40, 0, 0, 2'b01, 1); run(0, 1);
      chk("half_sext", rv_data[1], 32'hFFFFABCD);

      // reset in the middle of a store's ACCESS cycle
      set_cmd(0, 32'h80, 32'h55AA55AA, 1, 2'b10, 0);
      n0 = rv_cnt[0];
      @(posedge clk); #1;
      m0_if.req = 1'b1;
      got = 1'b0; n = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         got = m0_if.gnt;
         n++;
      end
      chk("mid_rst_gnt", got, 1);
      @(posedge clk); #1;
      m0_if.req = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ram_we", ram_we, 0);
      #2 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_rst_no_rvalid", rv_cnt[0], n0);
      set_cmd(0, 32'h80, 0, 0, 2'b10, 0); run(1, 0);
      chk("mid_rst_prior_data", rv_data[0], 32'hD9D8DBDA);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
